fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_unit_next_pc_gen.sv | 32 +++
 rtl/fetch_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit and the instruction decoder:
// branch-class encodings, fetch FSM states and the reset NOP word.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_COND = 2'b01,
      BR_JALR = 2'b10,
      BR_JAL  = 2'b11
   } br_type_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_HALT
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
   localparam logic [31:0] INSTR_BYTES = 32'd4;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_unit_next_pc_gen.sv
// Combinational next-PC selection from the decoder branch class, plus the
// word-alignment check on the selected target.
module next_pc_gen
   import fetch_unit_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [1:0]  br_type,
   input  logic        br_taken,
   input  logic [31:0] imm_val,
   input  logic [31:0] jalr_target,
   output logic [31:0] pc_plus4,
   output logic [31:0] next_pc,
   output logic        misalign
);

   logic [31:0] pc_plus_imm;

   always_comb begin
      pc_plus4    = pc + INSTR_BYTES;
      pc_plus_imm = pc + imm_val;
      next_pc     = pc_plus4;
      case (br_type)
         BR_NONE: next_pc = pc_plus4;
         BR_COND: next_pc = br_taken ? pc_plus_imm : pc_plus4;
         BR_JAL:  next_pc = pc_plus_imm;
         BR_JALR: next_pc = {jalr_target[31:1], 1'b0};
         default: next_pc = pc_plus4;
      endcase
      misalign = is_misaligned(next_pc);
   end

endmodule

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch sequencer: fetches the word at pc, holds it
// for the decoder until ex_done, then advances pc along the resolved branch.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic [1:0]  br_type,
   input  logic        br_taken,
   input  logic [31:0] imm_val,
   input  logic [31:0] jalr_target,
   input  logic        ex_done,
   output logic        misalign_err,
   output logic [31:0] retired
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  retired_q, retired_d;
   logic         imem_req_q, imem_req_d;
   logic         instr_valid_q, instr_valid_d;
   logic         misalign_err_q, misalign_err_d;

   logic [31:0]  next_pc;
   logic         next_misalign;

   next_pc_gen u_next_pc_gen (
      .pc          (pc_q),
      .br_type     (br_type),
      .br_taken    (br_taken),
      .imm_val     (imm_val),
      .jalr_target (jalr_target),
      .pc_plus4    (pc_plus4),
      .next_pc     (next_pc),
      .misalign    (next_misalign)
   );

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      instr_d        = instr_q;
      retired_d      = retired_q;
      misalign_err_d = misalign_err_q;
      case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            if (imem_rvalid) begin
               instr_d = imem_rdata;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            // A misaligned target still retires and commits pc before halting.
            if (ex_done) begin
               pc_d      = next_pc;
               retired_d = retired_q + 32'd1;
               if (next_misalign) begin
                  misalign_err_d = 1'b1;
                  state_d        = ST_HALT;
               end else begin
                  state_d = ST_FETCH;
               end
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_HALT;
      endcase
      imem_req_d    = (state_d == ST_FETCH);
      instr_valid_d = (state_d == ST_EXEC);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         pc_q           <= RESET_PC;
         instr_q        <= NOP_INSTR;
         retired_q      <= '0;
         imem_req_q     <= 1'b0;
         instr_valid_q  <= 1'b0;
         misalign_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         instr_q        <= instr_d;
         retired_q      <= retired_d;
         imem_req_q     <= imem_req_d;
         instr_valid_q  <= instr_valid_d;
         misalign_err_q <= misalign_err_d;
      end
   end

   assign imem_req     = imem_req_q;
   assign imem_addr    = pc_q;
   assign pc           = pc_q;
   assign instr        = instr_q;
   assign instr_valid  = instr_valid_q;
   assign misalign_err = misalign_err_q;
   assign retired      = retired_q;

endmodule
